// File: rtl/coin_pkg.sv
// coin_pkg: shared types and constants for the collectible coin sprite.
//   coin_state_t    - SPIN / POP / GONE, also the encoding seen on state_o.
//   rom_base_stride - sprite ROM words per animation frame (width * height).
//   BG_COLOR        - background colour used by the colour mapper.
package coin_pkg;

  typedef enum logic [1:0] {
    SPIN = 2'd0,
    POP  = 2'd1,
    GONE = 2'd2
  } coin_state_t;

  function automatic int unsigned rom_base_stride(input int unsigned w, input int unsigned h);
    return w * h;
  endfunction

  localparam logic [23:0] BG_COLOR = 24'h6b8cff;

endpackage

// File: rtl/coin_anim_n_if.sv
// coin_anim_n_if: pixel query bus between the VGA scan side and a sprite.
//   DrawX, DrawY - current screen pixel (scan side drives)
//   process      - horizontal world scroll offset (scan side drives)
//   coin         - pixel hit flag, one Clk after the query (sprite drives)
//   rom_addr     - sprite ROM address aligned with coin (sprite drives)
interface coin_anim_n_if #(
  parameter int unsigned ADDR_W = 11
) ();

  logic [9:0]        DrawX;
  logic [9:0]        DrawY;
  logic [9:0]        process;
  logic              coin;
  logic [ADDR_W-1:0] rom_addr;

  modport master (
    output DrawX,
    output DrawY,
    output process,
    input  coin,
    input  rom_addr
  );

  modport slave (
    input  DrawX,
    input  DrawY,
    input  process,
    output coin,
    output rom_addr
  );

endinterface

// File: rtl/frame_tick_gen.sv
// frame_tick_gen: turns the vsync-rate frame_clk level into a one-Clk tick.
//   Clk, Reset - system clock, synchronous active-high reset
//   frame_clk  - frame strobe, already synchronous to Clk
//   tick       - one-Clk pulse, two Clk after a frame_clk rising edge
module frame_tick_gen (
  input  logic Clk,
  input  logic Reset,
  input  logic frame_clk,
  output logic tick
);

  logic frame_clk_q;
  logic tick_q;
  logic rise;

  assign rise = frame_clk & ~frame_clk_q;
  assign tick = tick_q;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      frame_clk_q <= 1'b0;
      tick_q      <= 1'b0;
    end else begin
      frame_clk_q <= frame_clk;
      tick_q      <= rise;
    end
  end

endmodule

// File: rtl/coin_anim_n.sv
// coin_anim_n: one spinning collectible in a horizontally scrolled world.
// Spins through NUM_FRAMES frames, plays a rising pop when collected (with a
// one-Clk score_pulse), then disappears; optionally respawns at its origin.
//   Clk, Reset  - system clock, synchronous active-high reset
//   frame_clk   - vsync-rate strobe; all animation steps on its derived tick
//   collect     - player collision, level sensitive
//   pix         - pixel query bus (DrawX/DrawY/process in, coin/rom_addr out)
//   frame_idx   - current animation frame
//   coin_x/y    - current world position of the sprite top-left
//   state_o     - current coin_state_t
//   score_pulse - one Clk high on the SPIN to POP transition
module coin_anim_n
  import coin_pkg::*;
#(
  parameter int unsigned NUM_FRAMES    = 4,
  parameter int unsigned FRAME_HOLD    = 4,
  parameter int unsigned SPRITE_W      = 16,
  parameter int unsigned SPRITE_H      = 28,
  parameter int unsigned X_ORI         = 400,
  parameter int unsigned Y_ORI         = 300,
  parameter int unsigned POP_STEP      = 4,
  parameter int unsigned POP_TICKS     = 8,
  parameter int unsigned RESPAWN       = 0,
  parameter int unsigned RESPAWN_TICKS = 120,
  parameter int unsigned ADDR_W        = 11
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             frame_clk,
  input  logic             collect,
  coin_anim_n_if.slave     pix,
  output logic [3:0]       frame_idx,
  output logic [9:0]       coin_x,
  output logic [9:0]       coin_y,
  output coin_state_t      state_o,
  output logic             score_pulse
);

  localparam int unsigned Stride    = rom_base_stride(SPRITE_W, SPRITE_H);
  localparam logic [3:0]  LastFrame = 4'(NUM_FRAMES - 1);
  localparam logic [7:0]  LastHold  = 8'(FRAME_HOLD - 1);
  localparam logic [7:0]  LastPop   = 8'(POP_TICKS - 1);
  localparam logic [7:0]  LastResp  = 8'(RESPAWN_TICKS - 1);
  localparam logic [9:0]  XOri      = 10'(X_ORI);
  localparam logic [9:0]  YOri      = 10'(Y_ORI);
  localparam logic [9:0]  PopStep   = 10'(POP_STEP);
  localparam logic [10:0] SpriteW   = 11'(SPRITE_W);
  localparam logic [10:0] SpriteH   = 11'(SPRITE_H);

  logic tick;

  coin_state_t       state_q, state_d;
  logic [9:0]        x_q, x_d;
  logic [9:0]        y_q, y_d;
  logic [3:0]        frame_q, frame_d;
  logic [7:0]        hold_q, hold_d;
  logic [7:0]        aux_q, aux_d;
  logic              pulse_q, pulse_d;
  logic              coin_d;
  logic [ADDR_W-1:0] rom_d;

  logic [3:0]        frame_adv;
  logic [7:0]        hold_adv;
  logic [10:0]       wx, dx, dy;

  frame_tick_gen u_tick (
    .Clk       (Clk),
    .Reset     (Reset),
    .frame_clk (frame_clk),
    .tick      (tick)
  );

  // State register.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q      <= SPIN;
      x_q          <= XOri;
      y_q          <= YOri;
      frame_q      <= '0;
      hold_q       <= '0;
      aux_q        <= '0;
      pulse_q      <= 1'b0;
      pix.coin     <= 1'b0;
      pix.rom_addr <= '0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      frame_q      <= frame_d;
      hold_q       <= hold_d;
      aux_q        <= aux_d;
      pulse_q      <= pulse_d;
      pix.coin     <= coin_d;
      pix.rom_addr <= rom_d;
    end
  end

  // Spin-frame step taken on a tick in SPIN or POP.
  always_comb begin
    frame_adv = frame_q;
    hold_adv  = hold_q + 8'd1;
    if (hold_q == LastHold) begin
      hold_adv  = '0;
      frame_adv = (frame_q == LastFrame) ? 4'd0 : frame_q + 4'd1;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    frame_d = frame_q;
    hold_d  = hold_q;
    aux_d   = aux_q;
    unique case (state_q)
      SPIN: begin
        // Collection wins over a coincident tick; that tick's advance is lost.
        if (collect) begin
          state_d = POP;
          frame_d = '0;
          hold_d  = '0;
          aux_d   = '0;
        end else if (tick) begin
          frame_d = frame_adv;
          hold_d  = hold_adv;
        end
      end
      POP: begin
        if (tick) begin
          frame_d = frame_adv;
          hold_d  = hold_adv;
          y_d     = (y_q >= PopStep) ? y_q - PopStep : 10'd0;
          if (aux_q == LastPop) begin
            state_d = GONE;
            aux_d   = '0;
          end else begin
            aux_d = aux_q + 8'd1;
          end
        end
      end
      GONE: begin
        if (RESPAWN != 0 && tick) begin
          if (aux_q == LastResp) begin
            state_d = SPIN;
            x_d     = XOri;
            y_d     = YOri;
            frame_d = '0;
            hold_d  = '0;
            aux_d   = '0;
          end else begin
            aux_d = aux_q + 8'd1;
          end
        end
      end
      default: state_d = SPIN;
    endcase
  end

  // Outputs: score pulse and the per-pixel hit test.
  always_comb begin
    pulse_d = (state_q == SPIN) && collect;
    // 11-bit arithmetic so DrawX + process cannot wrap.
    wx     = {1'b0, pix.DrawX} + {1'b0, pix.process};
    dx     = wx - {1'b0, x_q};
    dy     = {1'b0, pix.DrawY} - {1'b0, y_q};
    coin_d = (state_q != GONE) && (wx >= {1'b0, x_q}) && (dx < SpriteW) &&
             (pix.DrawY >= y_q) && (dy < SpriteH);
    rom_d  = '0;
    if (coin_d) begin
      rom_d = ADDR_W'(32'(frame_q) * Stride + 32'(dy) * SPRITE_W + 32'(dx));
    end
  end

  assign frame_idx   = frame_q;
  assign coin_x      = x_q;
  assign coin_y      = y_q;
  assign state_o     = state_q;
  assign score_pulse = pulse_q;

endmodule

// File: tb/tb_coin_anim_n.sv
// tb_coin_anim_n: randomized and directed stimulus against a behavioural model.
// Two instances share stimulus: dut0 with defaults (GONE is terminal) and dut1
// with RESPAWN=1, RESPAWN_TICKS=3.
module tb_coin_anim_n;
  import coin_pkg::*;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       frame_clk = 1'b0;
  logic       collect = 1'b0;
  logic [9:0] drawx = '0;
  logic [9:0] drawy = '0;
  logic [9:0] proc_off = '0;

  logic [3:0]  fi0, fi1;
  logic [9:0]  cx0, cy0, cx1, cy1;
  coin_state_t st0, st1;
  logic        sp0, sp1;

  coin_anim_n_if #(.ADDR_W(11)) pix0 ();
  coin_anim_n_if #(.ADDR_W(11)) pix1 ();

  assign pix0.DrawX   = drawx;
  assign pix0.DrawY   = drawy;
  assign pix0.process = proc_off;
  assign pix1.DrawX   = drawx;
  assign pix1.DrawY   = drawy;
  assign pix1.process = proc_off;

  coin_anim_n dut0 (
    .Clk         (Clk),
    .Reset       (Reset),
    .frame_clk   (frame_clk),
    .collect     (collect),
    .pix         (pix0),
    .frame_idx   (fi0),
    .coin_x      (cx0),
    .coin_y      (cy0),
    .state_o     (st0),
    .score_pulse (sp0)
  );

  coin_anim_n #(.RESPAWN(1), .RESPAWN_TICKS(3)) dut1 (
    .Clk         (Clk),
    .Reset       (Reset),
    .frame_clk   (frame_clk),
    .collect     (collect),
    .pix         (pix1),
    .frame_idx   (fi1),
    .coin_x      (cx1),
    .coin_y      (cy1),
    .state_o     (st1),
    .score_pulse (sp1)
  );

  always #5 Clk = ~Clk;

  int vectors = 0;
  int miscompares = 0;

  // Behavioural model of what the outputs must read after a clock edge.
  typedef struct {
    int st; int x; int y; int frame; int hold; int aux; int pulse; int coin; int addr;
  } mdl_t;

  mdl_t m0, m1;
  bit   h1 = 1'b0, h2 = 1'b0;
  bit   mvalid = 1'b0;

  function automatic mdl_t step(input mdl_t m, input bit rst, input bit tk, input bit col,
                                input int dxin, input int dyin, input int pr,
                                input int rsp, input int rticks);
    mdl_t n = m;
    int   wx, ddx, ddy;
    bit   hit;
    if (rst) begin
      n.st = 0; n.x = 400; n.y = 300; n.frame = 0; n.hold = 0; n.aux = 0;
      n.pulse = 0; n.coin = 0; n.addr = 0;
      return n;
    end
    wx  = dxin + pr;
    ddx = wx - m.x;
    ddy = dyin - m.y;
    hit = (m.st != 2) && ddx >= 0 && ddx < 16 && ddy >= 0 && ddy < 28;
    n.coin  = hit ? 1 : 0;
    n.addr  = hit ? (m.frame * 448 + ddy * 16 + ddx) % 2048 : 0;
    n.pulse = (m.st == 0 && col) ? 1 : 0;
    if (m.st == 0 && col) begin
      n.st = 1; n.frame = 0; n.hold = 0; n.aux = 0;
    end else if (tk) begin
      if (m.st != 2) begin
        if (m.hold == 3) begin
          n.hold  = 0;
          n.frame = (m.frame + 1) % 4;
        end else begin
          n.hold = m.hold + 1;
        end
      end
      if (m.st == 1) begin
        n.y = (m.y >= 4) ? m.y - 4 : 0;
        if (m.aux == 7) begin n.st = 2; n.aux = 0; end
        else n.aux = m.aux + 1;
      end else if (m.st == 2 && rsp != 0) begin
        if (m.aux == rticks - 1) begin
          n.st = 0; n.x = 400; n.y = 300; n.frame = 0; n.hold = 0; n.aux = 0;
        end else begin
          n.aux = m.aux + 1;
        end
      end
    end
    return n;
  endfunction

  // Model update: tick is the frame_clk rise seen two samples back.
  always @(posedge Clk) begin
    bit tk;
    tk = h1 & ~h2;
    m0 = step(m0, Reset, tk, collect, int'(drawx), int'(drawy), int'(proc_off), 0, 3);
    m1 = step(m1, Reset, tk, collect, int'(drawx), int'(drawy), int'(proc_off), 1, 3);
    if (Reset) begin
      h1 = 1'b0; h2 = 1'b0; mvalid = 1'b1;
    end else begin
      h2 = h1; h1 = frame_clk;
    end
  end

  task automatic cmp(input string name, input mdl_t m, input int st, input int x, input int y,
                     input int fr, input int sp, input int cn, input int ad);
    vectors++;
    if (st != m.st || x != m.x || y != m.y || fr != m.frame || sp != m.pulse ||
        cn != m.coin || ad != m.addr) begin
      miscompares++;
      $display("FAIL %s @%0t: got st=%0d x=%0d y=%0d fr=%0d sp=%0d coin=%0d addr=%0d, want st=%0d x=%0d y=%0d fr=%0d sp=%0d coin=%0d addr=%0d",
               name, $time, st, x, y, fr, sp, cn, ad,
               m.st, m.x, m.y, m.frame, m.pulse, m.coin, m.addr);
    end
  endtask

  always @(negedge Clk) begin
    if (mvalid) begin
      cmp("model_dut0", m0, int'(st0), int'(cx0), int'(cy0), int'(fi0), int'(sp0),
          int'(pix0.coin), int'(pix0.rom_addr));
      cmp("model_dut1", m1, int'(st1), int'(cx1), int'(cy1), int'(fi1), int'(sp1),
          int'(pix1.coin), int'(pix1.rom_addr));
    end
  end

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // One frame_clk pulse; returns at a negedge after its tick has taken effect.
  task automatic pulse_fc();
    frame_clk = 1'b1;
    @(negedge Clk);
    frame_clk = 1'b0;
    repeat (4) @(negedge Clk);
  endtask

  initial begin
    int cnt0, cnt1;
    repeat (3) @(negedge Clk);
    Reset = 1'b0;
    check("rst_state", int'(st0), 0);
    check("rst_x", int'(cx0), 400);
    check("rst_y", int'(cy0), 300);
    check("rst_frame", int'(fi0), 0);
    check("rst_coin", int'(pix0.coin), 0);
    check("rst_pulse", int'(sp0), 0);

    for (int k = 1; k <= 16; k++) begin
      pulse_fc();
      if (k == 3)  check("frame_after3", int'(fi0), 0);
      if (k == 4)  check("frame_after4", int'(fi0), 1);
      if (k == 15) check("frame_after15", int'(fi0), 3);
      if (k == 16) check("frame_wrap16", int'(fi0), 0);
    end
    check("spin_x", int'(cx0), 400);
    check("spin_y", int'(cy0), 300);

    drawx = 10'd400; drawy = 10'd300; proc_off = 10'd0;
    @(negedge Clk);
    check("hit_tl_coin", int'(pix0.coin), 1);
    check("hit_tl_addr", int'(pix0.rom_addr), 0);
    drawx = 10'd415; drawy = 10'd327;
    @(negedge Clk);
    check("hit_br_addr", int'(pix0.rom_addr), 447);
    drawx = 10'd416;
    @(negedge Clk);
    check("miss_right", int'(pix0.coin), 0);
    proc_off = 10'd100; drawx = 10'd300; drawy = 10'd300;
    @(negedge Clk);
    check("hit_scrolled", int'(pix0.coin), 1);

    cnt0 = 0;
    collect = 1'b1;
    repeat (50) begin
      @(negedge Clk);
      cnt0 += int'(sp0);
    end
    collect = 1'b0;
    check("held_collect_pulses", cnt0, 1);
    check("pop_state", int'(st0), 1);
    check("pop_frame", int'(fi0), 0);

    repeat (8) pulse_fc();
    check("gone_y", int'(cy0), 268);
    check("gone_state", int'(st0), 2);
    check("gone_state_r", int'(st1), 2);
    drawx = 10'd400; drawy = 10'd268; proc_off = 10'd0;
    @(negedge Clk);
    check("gone_no_coin", int'(pix0.coin), 0);

    repeat (3) pulse_fc();
    check("respawn_state", int'(st1), 0);
    check("respawn_x", int'(cx1), 400);
    check("respawn_y", int'(cy1), 300);
    check("respawn_frame", int'(fi1), 0);
    check("terminal_gone", int'(st0), 2);

    cnt0 = 0; cnt1 = 0;
    collect = 1'b1;
    repeat (10) begin
      @(negedge Clk);
      cnt0 += int'(sp0);
      cnt1 += int'(sp1);
    end
    collect = 1'b0;
    check("second_pulse", cnt1, 1);
    check("gone_ignores_collect", cnt0, 0);

    repeat (2) pulse_fc();
    Reset = 1'b1; collect = 1'b1;
    @(negedge Clk);
    Reset = 1'b0; collect = 1'b0;
    check("midpop_rst_state", int'(st1), 0);
    check("midpop_rst_y", int'(cy1), 300);
    check("midpop_rst_pulse", int'(sp1), 0);
    check("midpop_rst_frame", int'(fi1), 0);

    repeat (11) pulse_fc();
    check("pre_coincide_frame", int'(fi0), 2);
    frame_clk = 1'b1;
    @(negedge Clk);
    frame_clk = 1'b0; collect = 1'b1;
    @(negedge Clk);
    collect = 1'b0;
    check("coincide_pulse", int'(sp0), 1);
    check("coincide_state", int'(st0), 1);
    check("coincide_frame", int'(fi0), 0);
    @(negedge Clk);
    check("coincide_pulse_off", int'(sp0), 0);
    repeat (3) pulse_fc();
    check("coincide_hold_cleared", int'(fi0), 0);
    pulse_fc();
    check("coincide_frame_next", int'(fi0), 1);

    for (int i = 0; i < 4000; i++) begin
      frame_clk = ($urandom_range(0, 3) == 0);
      collect   = ($urandom_range(0, 29) == 0);
      Reset     = ($urandom_range(0, 399) == 0);
      if ($urandom_range(0, 7) == 0) begin
        drawx    = 10'($urandom_range(0, 1023));
        drawy    = 10'($urandom_range(0, 1023));
        proc_off = 10'($urandom_range(0, 1023));
      end else begin
        proc_off = 10'($urandom_range(0, 200));
        drawx    = 10'(385 + $urandom_range(0, 35) - int'(proc_off));
        drawy    = 10'($urandom_range(255, 335));
      end
      @(negedge Clk);
    end
    Reset = 1'b0; collect = 1'b0; frame_clk = 1'b0;
    repeat (4) @(negedge Clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/coin_anim_n.md
Name: coin_anim_n

Overview:
- Parametrised successor to the single-coin spinner: one collectible sprite that cycles through NUM_FRAMES animation frames at a configurable rate.
- On collection it plays a rising "pop" animation, emits a one-cycle score pulse, then disappears. With RESPAWN set, it returns to its origin after a fixed delay.
- Sits between the level/collision logic and the colour mapper. It produces a per-pixel hit flag and a sprite-ROM address for the current VGA pixel in a horizontally scrolled world.

Parameters:
- NUM_FRAMES, 4, number of spin frames (2..16).
- FRAME_HOLD, 4, frame ticks each frame is held (1..255).
- SPRITE_W, 16, sprite width in pixels.
- SPRITE_H, 28, sprite height in pixels.
- X_ORI, 400, world x of coin top-left after reset or respawn.
- Y_ORI, 300, world y of coin top-left after reset or respawn.
- POP_STEP, 4, pixels coin_y decreases per frame tick in POP.
- POP_TICKS, 8, frame ticks spent in POP.
- RESPAWN, 0, 1 = return to SPIN after GONE delay; 0 = GONE is terminal.
- RESPAWN_TICKS, 120, frame ticks spent in GONE before respawn.
- ADDR_W, 11, sprite ROM address width; must satisfy 2^ADDR_W >= NUM_FRAMES*SPRITE_W*SPRITE_H.

Ports:
- Clk  in  1  system clock; single clock domain.
- Reset  in  1  synchronous, active-high reset.
- frame_clk  in  1  VGA vsync-rate strobe, synchronous to Clk.
- DrawX  in  10  current screen pixel x.
- DrawY  in  10  current screen pixel y.
- process  in  10  world scroll offset; world x = DrawX + process.
- collect  in  1  collision with player; level sensitive, sampled every Clk.
- coin  out  1  current pixel lies inside the visible sprite; registered.
- rom_addr  out  ADDR_W  sprite ROM address for the current pixel; registered, aligned with coin.
- frame_idx  out  4  current animation frame.
- coin_x  out  10  current world x.
- coin_y  out  10  current world y.
- state_o  out  2  current state, encoded as coin_state_t.
- score_pulse  out  1  one-Clk pulse on collection.

Behaviour:
- Reset values: state SPIN, coin_x=X_ORI, coin_y=Y_ORI, frame_idx=0, hold_cnt=0, aux_cnt=0, coin=0, rom_addr=0, score_pulse=0. Reset overrides every other input.
- Tick generation:
  - frame_clk is registered once; rise = frame_clk & ~frame_clk_q.
  - tick is rise registered, so tick is a one-Clk pulse two Clk after the frame_clk rising edge.
  - All animation updates occur only on tick cycles.
- Frame advance (SPIN and POP only), on tick:
  - If hold_cnt == FRAME_HOLD-1: hold_cnt=0 and frame_idx=(frame_idx+1) mod NUM_FRAMES, wrapping NUM_FRAMES-1 to 0.
  - Otherwise hold_cnt+1.
- SPIN:
  - collect=1 causes the next state POP, with frame_idx=0, hold_cnt=0, aux_cnt=0, and score_pulse=1 for exactly that one cycle.
  - If collect and tick coincide, the collect effects apply and the tick advance is discarded.
- POP:
  - collect is ignored.
  - On tick: coin_y -= POP_STEP, saturating at 0; aux_cnt+1.
  - On the tick where aux_cnt == POP_TICKS-1: go to GONE, aux_cnt=0.
- GONE:
  - coin is forced to 0; collect is ignored.
  - If RESPAWN=1, then on tick: aux_cnt+1. At aux_cnt == RESPAWN_TICKS-1, go to SPIN with coin_x=X_ORI, coin_y=Y_ORI, frame_idx=0, hold_cnt=0.
  - If RESPAWN=0, GONE persists until Reset.
- Hit test, evaluated every Clk:
  - All arithmetic is done at 11 bits to avoid wrap: wx = DrawX + process, dx = wx - coin_x, dy = DrawY - coin_y.
  - hit = (state != GONE) & wx >= coin_x & dx < SPRITE_W & DrawY >= coin_y & dy < SPRITE_H. Bounds are inclusive on the low side and exclusive on the high side.
  - coin <= hit.
  - rom_addr <= hit ? frame_idx*SPRITE_W*SPRITE_H + dy*SPRITE_W + dx : 0.
  - Latency from DrawX/DrawY to coin/rom_addr is exactly 1 Clk; the colour mapper compensates.
- score_pulse never asserts outside the SPIN-to-POP transition, so a held collect yields exactly one pulse.

Decomposition:
- Package coin_pkg holds:
  - typedef enum logic [1:0] coin_state_t {SPIN=0, POP=1, GONE=2}.
  - localparam ROM_BASE_STRIDE function (W*H).
  - BG_COLOR 24'h6b8cff, for mapper use.
- One sub-module: frame_tick_gen (frame_clk to tick edge detector, two flops), shared with other animated sprites.

Test Plan:
- Reset, then 16 frame_clk pulses with defaults -> frame_idx sequence 0,0,0,0,1,...; wraps 3 to 0 on the 16th tick; coin_x=400, coin_y=300 throughout.
- DrawX=400, DrawY=300, process=0 -> coin=1, rom_addr=0 one Clk later. DrawX=415, DrawY=327 -> rom_addr=447. DrawX=416 -> coin=0. process=100, DrawX=300, DrawY=300 -> coin=1.
- collect held high for 50 Clk in SPIN -> score_pulse high for exactly 1 Clk, state POP, frame_idx=0. After 8 ticks: coin_y=268 and state GONE; coin=0 at DrawX=400, DrawY=268.
- collect asserted on the same Clk as tick, with frame_idx=2 and hold_cnt=3 -> frame_idx=0, hold_cnt=0, state POP, one score_pulse.
- RESPAWN=1, RESPAWN_TICKS=3: collect, then 8+3 ticks -> state SPIN, coin_x=400, coin_y=300, frame_idx=0. A second collect gives a second score_pulse.
- Reset asserted mid-POP, with collect=1 on the same cycle -> state SPIN, coin_y=300, score_pulse=0, all counters 0.
